// File: rtl/pc_unit.sv
// Program counter with one-cycle boot state, sequential/branch/jump/jr next-PC
// selection, a 1-deep pending redirect, and a single-level exception/return path.
module pc_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 'h0000_4180
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_ready,
  input  logic             stall,
  input  logic [1:0]       npc_sel,
  input  logic             br_taken,
  input  logic [15:0]      br_offset,
  input  logic [25:0]      j_index,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             pc_valid,
  output logic [WIDTH-1:0] epc,
  output logic             in_exc
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             in_exc_q, in_exc_d;
  logic             pend_v_q, pend_v_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;

  logic [WIDTH-1:0]        pc_plus4_w;
  logic signed [WIDTH-1:0] br_disp;
  logic [WIDTH-1:0]        br_tgt;
  logic [WIDTH-1:0]        j_tgt;
  logic [WIDTH-1:0]        redir_tgt;
  logic                    redir;
  logic                    jr_misalign;
  logic                    exc;
  logic                    adv;

  assign pc_plus4_w = pc_q + {{(WIDTH-3){1'b0}}, 3'd4};
  // Word offset becomes a byte displacement; sign extension keeps backward branches negative.
  assign br_disp    = {{(WIDTH-18){br_offset[15]}}, br_offset, 2'b00};
  assign br_tgt     = pc_plus4_w + $unsigned(br_disp);
  assign j_tgt      = {pc_plus4_w[WIDTH-1:28], j_index, 2'b00};

  assign redir       = (npc_sel == 2'b10) || (npc_sel == 2'b11) ||
                       ((npc_sel == 2'b01) && br_taken);
  assign jr_misalign = (npc_sel == 2'b11) && (jr_target[1:0] != 2'b00);
  assign exc         = exc_req || jr_misalign;
  assign adv         = (state_q == RUN) && imem_ready && !stall;

  always_comb begin
    case (npc_sel)
      2'b01:   redir_tgt = br_tgt;
      2'b10:   redir_tgt = j_tgt;
      2'b11:   redir_tgt = jr_target;
      default: redir_tgt = pc_plus4_w;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    in_exc_d  = in_exc_q;
    pend_v_d  = pend_v_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        // Exception entry and return bypass the fetch handshake entirely.
        if (exc && !in_exc_q) begin
          pc_d     = EXC_VECTOR;
          epc_d    = pc_q;
          in_exc_d = 1'b1;
          pend_v_d = 1'b0;
        end else if (eret && in_exc_q) begin
          pc_d     = epc_q;
          in_exc_d = 1'b0;
          pend_v_d = 1'b0;
        end else if (adv) begin
          pc_d     = redir ? redir_tgt : (pend_v_q ? pend_pc_q : pc_plus4_w);
          pend_v_d = 1'b0;
        end else if (redir) begin
          pend_pc_d = redir_tgt;
          pend_v_d  = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      epc_q    <= '0;
      in_exc_q <= 1'b0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      in_exc_q <= in_exc_d;
      pend_v_q <= pend_v_d;
    end
  end

  // Pending target is only meaningful while pend_v_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_pc_q <= pend_pc_d;
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_w;
  assign pc_valid = (state_q == RUN);
  assign epc      = epc_q;
  assign in_exc   = in_exc_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a 32-bit and a 64-bit instance driven with
// directed vectors whose post-edge state is queued and checked by monitors.
module tb_pc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic        v;
    logic [63:0] epc;
    logic        ie;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   total = 0;
  int   bad   = 0;

  // 32-bit instance signals
  logic        rst32, ir32, st32, bt32, er32, et32;
  logic [1:0]  ns32;
  logic [15:0] bo32;
  logic [25:0] ji32;
  logic [31:0] jt32;
  logic [31:0] pc32, pcp32, epc32;
  logic        v32, ie32;

  // 64-bit instance signals
  logic        rst64, ir64, st64, bt64, er64, et64;
  logic [1:0]  ns64;
  logic [15:0] bo64;
  logic [25:0] ji64;
  logic [63:0] jt64;
  logic [63:0] pc64, pcp64, epc64;
  logic        v64, ie64;

  pc_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst32), .imem_ready(ir32), .stall(st32), .npc_sel(ns32),
    .br_taken(bt32), .br_offset(bo32), .j_index(ji32), .jr_target(jt32),
    .exc_req(er32), .eret(et32), .pc(pc32), .pc_plus4(pcp32), .pc_valid(v32),
    .epc(epc32), .in_exc(ie32)
  );

  pc_unit #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(rst64), .imem_ready(ir64), .stall(st64), .npc_sel(ns64),
    .br_taken(bt64), .br_offset(bo64), .j_index(ji64), .jr_target(jt64),
    .exc_req(er64), .eret(et64), .pc(pc64), .pc_plus4(pcp64), .pc_valid(v64),
    .epc(epc64), .in_exc(ie64)
  );

  task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  initial begin : mon32
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q32.size() != 0) begin
        e = q32.pop_front();
        chk(e.name, "pc",       {32'h0, pc32},  e.pc);
        chk(e.name, "pc_plus4", {32'h0, pcp32}, {32'h0, e.pc[31:0] + 32'd4});
        chk(e.name, "pc_valid", {63'h0, v32},   {63'h0, e.v});
        chk(e.name, "epc",      {32'h0, epc32}, e.epc);
        chk(e.name, "in_exc",   {63'h0, ie32},  {63'h0, e.ie});
      end
    end
  end

  initial begin : mon64
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q64.size() != 0) begin
        e = q64.pop_front();
        chk(e.name, "pc",       pc64,          e.pc);
        chk(e.name, "pc_plus4", pcp64,         e.pc + 64'd4);
        chk(e.name, "pc_valid", {63'h0, v64},  {63'h0, e.v});
        chk(e.name, "epc",      epc64,         e.epc);
        chk(e.name, "in_exc",   {63'h0, ie64}, {63'h0, e.ie});
      end
    end
  end

  task automatic idle32();
    ir32 = 1'b1; st32 = 1'b0; ns32 = 2'b00; bt32 = 1'b0; bo32 = 16'h0;
    ji32 = 26'h0; jt32 = 32'h0; er32 = 1'b0; et32 = 1'b0;
  endtask

  task automatic idle64();
    ir64 = 1'b1; st64 = 1'b0; ns64 = 2'b00; bt64 = 1'b0; bo64 = 16'h0;
    ji64 = 26'h0; jt64 = 64'h0; er64 = 1'b0; et64 = 1'b0;
  endtask

  // Inputs are already set; queue the state expected after the next rising edge.
  task automatic go32(input string nm, input logic [63:0] p, input logic v, input logic [63:0] ep, input logic ie);
    exp_t e;
    e.name = nm; e.pc = p; e.v = v; e.epc = ep; e.ie = ie;
    q32.push_back(e);
    @(posedge clk);
    @(negedge clk);
    idle32();
  endtask

  task automatic go64(input string nm, input logic [63:0] p, input logic v, input logic [63:0] ep, input logic ie);
    exp_t e;
    e.name = nm; e.pc = p; e.v = v; e.epc = ep; e.ie = ie;
    q64.push_back(e);
    @(posedge clk);
    @(negedge clk);
    idle64();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst32 = 1'b0; rst64 = 1'b0;
    idle32(); idle64();

    go32("reset_a", 64'h3000, 1'b0, 64'h0, 1'b0);
    go32("reset_b", 64'h3000, 1'b0, 64'h0, 1'b0);

    rst32 = 1'b1; ns32 = 2'b10; ji32 = 26'h0C40; er32 = 1'b1;
    go32("boot_ignore", 64'h3000, 1'b1, 64'h0, 1'b0);
    go32("seq1", 64'h3004, 1'b1, 64'h0, 1'b0);
    go32("seq2", 64'h3008, 1'b1, 64'h0, 1'b0);
    go32("seq3", 64'h300C, 1'b1, 64'h0, 1'b0);
    go32("seq4", 64'h3010, 1'b1, 64'h0, 1'b0);

    ns32 = 2'b01; bt32 = 1'b1; bo32 = 16'hFFFC;
    go32("br_back", 64'h3004, 1'b1, 64'h0, 1'b0);
    ns32 = 2'b01; bt32 = 1'b0; bo32 = 16'hFFFC;
    go32("br_not_taken", 64'h3008, 1'b1, 64'h0, 1'b0);
    for (int i = 1; i <= 6; i++) go32("walk", 64'h3008 + 64'(4 * i), 1'b1, 64'h0, 1'b0);

    ir32 = 1'b0; ns32 = 2'b10; ji32 = 26'h0C40;
    go32("jmp_hold1", 64'h3020, 1'b1, 64'h0, 1'b0);
    ir32 = 1'b0;
    go32("jmp_hold2", 64'h3020, 1'b1, 64'h0, 1'b0);
    go32("jmp_pend", 64'h3100, 1'b1, 64'h0, 1'b0);
    go32("pend_clr", 64'h3104, 1'b1, 64'h0, 1'b0);
    st32 = 1'b1;
    go32("stall", 64'h3104, 1'b1, 64'h0, 1'b0);
    ns32 = 2'b10; ji32 = 26'h0C10;
    go32("jmp_3040", 64'h3040, 1'b1, 64'h0, 1'b0);

    st32 = 1'b1; er32 = 1'b1;
    go32("exc", 64'h4180, 1'b1, 64'h3040, 1'b1);
    st32 = 1'b1; er32 = 1'b1;
    go32("exc_nest", 64'h4180, 1'b1, 64'h3040, 1'b1);
    st32 = 1'b1; et32 = 1'b1;
    go32("eret", 64'h3040, 1'b1, 64'h3040, 1'b0);
    et32 = 1'b1;
    go32("eret_ign", 64'h3044, 1'b1, 64'h3040, 1'b0);

    ns32 = 2'b11; jt32 = 32'h3002;
    go32("jr_misalign", 64'h4180, 1'b1, 64'h3044, 1'b1);
    et32 = 1'b1;
    go32("eret2", 64'h3044, 1'b1, 64'h3044, 1'b0);
    ns32 = 2'b11; jt32 = 32'h3200;
    go32("jr_ok", 64'h3200, 1'b1, 64'h3044, 1'b0);
    ns32 = 2'b10; ji32 = 26'h0C40; er32 = 1'b1;
    go32("exc_prio", 64'h4180, 1'b1, 64'h3200, 1'b1);
    et32 = 1'b1; ns32 = 2'b01; bt32 = 1'b1; bo32 = 16'h0010;
    go32("eret_prio", 64'h3200, 1'b1, 64'h3200, 1'b0);

    ir32 = 1'b0; ns32 = 2'b10; ji32 = 26'h0CC0;
    go32("pend_a", 64'h3200, 1'b1, 64'h3200, 1'b0);
    ir32 = 1'b0; ns32 = 2'b11; jt32 = 32'h3400;
    go32("pend_b", 64'h3200, 1'b1, 64'h3200, 1'b0);
    go32("pend_ovr", 64'h3400, 1'b1, 64'h3200, 1'b0);
    ir32 = 1'b0; ns32 = 2'b10; ji32 = 26'h0D40;
    go32("pend_c", 64'h3400, 1'b1, 64'h3200, 1'b0);
    ns32 = 2'b01; bt32 = 1'b1; bo32 = 16'h0004;
    go32("live_ovr", 64'h3414, 1'b1, 64'h3200, 1'b0);
    go32("seq5", 64'h3418, 1'b1, 64'h3200, 1'b0);

    ir32 = 1'b0; ns32 = 2'b10; ji32 = 26'h0D80;
    go32("pend_d", 64'h3418, 1'b1, 64'h3200, 1'b0);
    rst32 = 1'b0;
    go32("rst_mid", 64'h3000, 1'b0, 64'h0, 1'b0);
    rst32 = 1'b1;
    go32("boot2", 64'h3000, 1'b1, 64'h0, 1'b0);
    go32("no_pend", 64'h3004, 1'b1, 64'h0, 1'b0);

    go64("w64_reset", 64'h3000, 1'b0, 64'h0, 1'b0);
    rst64 = 1'b1;
    go64("w64_boot", 64'h3000, 1'b1, 64'h0, 1'b0);
    ns64 = 2'b11; jt64 = 64'hFFFF_FFFC;
    go64("w64_jr", 64'hFFFF_FFFC, 1'b1, 64'h0, 1'b0);
    ns64 = 2'b01; bt64 = 1'b1; bo64 = 16'h0001;
    go64("w64_br", 64'h1_0000_0004, 1'b1, 64'h0, 1'b0);
    go64("w64_seq", 64'h1_0000_0008, 1'b1, 64'h0, 1'b0);
    ns64 = 2'b10; ji64 = 26'h10;
    go64("w64_jmp", 64'h1_0000_0040, 1'b1, 64'h0, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    total++;
    if (q32.size() != 0 || q64.size() != 0) begin
      bad++;
      $display("FAIL drain: left %0d/%0d expected 0/0", q32.size(), q64.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: PC/target width; legal range 32..64.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_3000: PC value held during reset.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h0000_4180: exception entry address.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port imem_ready, input, 1: instruction memory accepts the current pc this cycle.
REQ-007 SHALL have port stall, input, 1: pipeline hold request.
REQ-008 SHALL have port npc_sel, input, 2: 00 sequential, 01 branch, 10 jump, 11 jr.
REQ-009 SHALL have port br_taken, input, 1: branch condition; used only when npc_sel=01.
REQ-010 SHALL have port br_offset, input, 16: signed word offset.
REQ-011 SHALL have port j_index, input, 26: jump index.
REQ-012 SHALL have port jr_target, input, WIDTH: register jump target.
REQ-013 SHALL have port exc_req, input, 1: external exception request.
REQ-014 SHALL have port eret, input, 1: return from exception.
REQ-015 SHALL have port pc, output, WIDTH: current fetch address.
REQ-016 SHALL have port pc_plus4, output, WIDTH: pc+4, combinational.
REQ-017 SHALL have port pc_valid, output, 1: pc is a valid fetch request.
REQ-018 SHALL have port epc, output, WIDTH: saved exception PC.
REQ-019 SHALL have port in_exc, output, 1: exception handler active.

Function
REQ-020 SHALL implement states BOOT and RUN: BOOT lasts exactly one cycle after reset release, then RUN; pc_valid=1 only in RUN.
REQ-021 SHALL define advance (adv) = RUN & pc_valid & imem_ready & ~stall.
REQ-022 SHALL compute branch target = pc_plus4 + (sign-extended br_offset << 2), modulo 2^WIDTH.
REQ-023 SHALL compute jump target = {pc_plus4[WIDTH-1:28], j_index, 2'b00}.
REQ-024 SHALL treat a redirect as active when npc_sel=10, when npc_sel=11, or when npc_sel=01 with br_taken=1.
REQ-025 SHALL, on adv, load pc with the live redirect target if active, else the pending target if pend_v=1, else pc_plus4; pend_v then clears.
REQ-026 SHALL, on an active redirect without adv, store its target in a 1-deep pending register with pend_v=1; a later redirect overwrites it.
REQ-027 SHALL flag jr misalignment when npc_sel=11 and jr_target[1:0]!=0; the flag is treated exactly as exc_req.
REQ-028 SHALL, on exc (exc_req or misalignment) while in_exc=0, load pc<=EXC_VECTOR, epc<=pc, set in_exc=1 and clear pend_v, regardless of stall or imem_ready.
REQ-029 SHALL, on eret while in_exc=1, load pc<=epc, clear in_exc and clear pend_v, regardless of stall or imem_ready.
REQ-030 SHALL apply priority exc > eret > redirect/pending > sequential.
REQ-031 SHALL ignore exc while in_exc=1 (no nesting) and ignore eret while in_exc=0.
REQ-032 SHALL ignore all control inputs in BOOT.

Reset
REQ-033 SHALL, while reset=0, asynchronously force pc=RESET_PC, epc=0, in_exc=0, pend_v=0, pc_valid=0 and state=BOOT.
REQ-034 SHALL, on reset assertion mid-operation, discard any pending redirect or exception in progress.

Verification
REQ-035 SHALL cover reset release then 3 cycles with imem_ready=1 -> pc 3000, 3000 (BOOT, pc_valid=0), 3004, 3008.
REQ-036 SHALL cover pc=3010, npc_sel=01, br_taken=1, br_offset=16'hFFFC -> pc=3004 next edge.
REQ-037 SHALL cover pc=3020, jump redirect with imem_ready=0 for 2 cycles -> pc held at 3020, then pc=target on the first ready edge, pend_v=0.
REQ-038 SHALL cover pc=3040, stall=1, exc_req=1 -> pc=4180, epc=3040, in_exc=1; a second exc_req -> no change; eret -> pc=3040, in_exc=0.
REQ-039 SHALL cover npc_sel=11, jr_target=3002 -> pc=4180, epc=old pc.
REQ-040 SHALL cover WIDTH=64 instance and a branch from pc=FFFF_FFFC with offset +1 -> pc=1_0000_0004, with no truncation.
